// File: rtl/fp_decode_serial.sv
// Serial float expander: turns {sign, exp, sig} into a two's-complement linear value.
// The magnitude is shifted left one bit per cycle, exp times, then signed and presented.
module fp_decode_serial #(
    parameter int EXP_W = 3,
    parameter int SIG_W = 4,
    parameter int OUT_W = 12
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+SIG_W:0]   fp_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [OUT_W-1:0]       value,
    output logic                   busy
);

    localparam int MAG_W = OUT_W - 1;

    // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
    // in_ready is high only in ST_IDLE; out_valid holds with value until out_ready is seen.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [MAG_W-1:0]   mag_q, mag_d;
    logic [EXP_W-1:0]   cnt_q, cnt_d;
    logic               neg_q, neg_d;
    logic [OUT_W-1:0]   value_q, value_d;
    logic               out_valid_q, out_valid_d;
    logic [OUT_W-1:0]   ext_mag;

    assign ext_mag = {1'b0, mag_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            mag_q       <= '0;
            cnt_q       <= '0;
            neg_q       <= 1'b0;
            value_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mag_q       <= mag_d;
            cnt_q       <= cnt_d;
            neg_q       <= neg_d;
            value_q     <= value_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        mag_d       = mag_q;
        cnt_d       = cnt_q;
        neg_d       = neg_q;
        value_d     = value_q;
        out_valid_d = out_valid_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    mag_d   = MAG_W'(fp_in[SIG_W-1:0]);
                    cnt_d   = fp_in[SIG_W +: EXP_W];
                    neg_d   = fp_in[EXP_W+SIG_W];
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (cnt_q != '0) begin
                    mag_d = mag_q << 1;
                    cnt_d = cnt_q - EXP_W'(1);
                end else begin
                    // Negating a zero magnitude gives zero, so there is no -0 output.
                    value_d     = neg_q ? -ext_mag : ext_mag;
                    out_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign out_valid = out_valid_q;
    assign value     = value_q;

endmodule
